// File: rtl/banked_sram_ctrl_if.sv
// rtl/banked_sram_ctrl_if.sv - request/response and macro bus bundle for the banked SRAM controller
interface banked_sram_ctrl_if #(
    parameter int NUM_BANKS = 64,
    parameter int BANK_AW   = 10,
    parameter int DW        = 8
);
    localparam int AW = $clog2(NUM_BANKS) + BANK_AW;

    // Request channel
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [AW-1:0]           req_addr;
    logic [DW-1:0]           req_wdata;

    // Read response channel
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DW-1:0]           rsp_rdata;

    // Shared macro bus plus per-bank selects
    logic [BANK_AW-1:0]      mem_addr;
    logic                    mem_ce;
    logic                    mem_web;
    logic [NUM_BANKS-1:0]    mem_csb;
    logic [NUM_BANKS-1:0]    mem_oeb;
    logic [DW-1:0]           mem_idata;
    logic [NUM_BANKS*DW-1:0] mem_odata;

    // Environment side: issues requests, consumes responses, models the macros
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_odata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_addr, mem_ce, mem_web, mem_csb, mem_oeb, mem_idata
    );

    // Controller side
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_odata,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_addr, mem_ce, mem_web, mem_csb, mem_oeb, mem_idata
    );
endinterface

// File: rtl/banked_sram_ctrl.sv
// rtl/banked_sram_ctrl.sv - single-outstanding controller for an array of 1RW SRAM macro banks
module banked_sram_ctrl #(
    parameter int NUM_BANKS = 64,
    parameter int BANK_AW   = 10,
    parameter int DW        = 8,
    parameter int RD_LAT    = 1
) (
    input  logic               clk,
    input  logic               rstn,
    banked_sram_ctrl_if.slave  bus
);
    localparam int BW  = $clog2(NUM_BANKS);
    localparam int AW  = BW + BANK_AW;
    localparam int WCW = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t               state;
    logic [BW-1:0]        bank_q;
    logic                 we_q;
    logic [WCW-1:0]       wait_cnt;

    // Registered outputs; mem_addr and mem_idata double as the row and
    // write-data holding registers for the transaction in flight.
    logic                 req_ready_q;
    logic                 rsp_valid_q;
    logic [DW-1:0]        rsp_rdata_q;
    logic [BANK_AW-1:0]   mem_addr_q;
    logic                 mem_ce_q;
    logic                 mem_web_q;
    logic [NUM_BANKS-1:0] mem_csb_q;
    logic [NUM_BANKS-1:0] mem_oeb_q;
    logic [DW-1:0]        mem_idata_q;

    logic [NUM_BANKS-1:0] acc_csb;
    logic [DW-1:0]        odata_slice;

    // Active-low select for the bank addressed by the incoming request
    always_comb begin
        acc_csb = '1;
        acc_csb[bus.req_addr[AW-1:BANK_AW]] = 1'b0;
    end

    assign odata_slice = bus.mem_odata[int'(bank_q)*DW +: DW];

    // Transaction sequencer: accept, strobe the macro, wait out read latency, hold response
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            bank_q      <= '0;
            we_q        <= 1'b0;
            wait_cnt    <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_ce_q    <= 1'b0;
            mem_web_q   <= 1'b1;
            mem_csb_q   <= '1;
            mem_oeb_q   <= '1;
            mem_idata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bank_q      <= bus.req_addr[AW-1:BANK_AW];
                        we_q        <= bus.req_we;
                        mem_addr_q  <= bus.req_addr[BANK_AW-1:0];
                        mem_idata_q <= bus.req_wdata;
                        mem_ce_q    <= 1'b1;
                        mem_web_q   <= ~bus.req_we;
                        mem_csb_q   <= acc_csb;
                        req_ready_q <= 1'b0;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_ce_q  <= 1'b0;
                    mem_web_q <= 1'b1;
                    if (we_q) begin
                        mem_csb_q   <= '1;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        // Keep the bank selected and open its output driver
                        mem_oeb_q <= mem_csb_q;
                        wait_cnt  <= WCW'(RD_LAT - 1);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        rsp_rdata_q <= odata_slice;
                        rsp_valid_q <= 1'b1;
                        mem_csb_q   <= '1;
                        mem_oeb_q   <= '1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    mem_ce_q    <= 1'b0;
                    mem_web_q   <= 1'b1;
                    mem_csb_q   <= '1;
                    mem_oeb_q   <= '1;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_ce    = mem_ce_q;
    assign bus.mem_web   = mem_web_q;
    assign bus.mem_csb   = mem_csb_q;
    assign bus.mem_oeb   = mem_oeb_q;
    assign bus.mem_idata = mem_idata_q;
endmodule

// File: tb/tb_banked_sram_ctrl.sv
// tb/tb_banked_sram_ctrl.sv - randomized self-checking bench for banked_sram_ctrl
module tb_banked_sram_ctrl;
    localparam int NB      = 64;
    localparam int BANK_AW = 10;
    localparam int DW      = 8;
    localparam int RD_LAT  = 1;
    localparam int BW      = $clog2(NB);
    localparam int AW      = BW + BANK_AW;
    localparam int ROWS    = 1 << BANK_AW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    banked_sram_ctrl_if #(.NUM_BANKS(NB), .BANK_AW(BANK_AW), .DW(DW)) bus ();

    banked_sram_ctrl #(.NUM_BANKS(NB), .BANK_AW(BANK_AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Reference model: what each address should hold after completed writes
    bit [DW-1:0]     ref_mem [int];
    logic [AW-1:0]   written [$];

    // External macro array: 1RW per bank, data appears RD_LAT cycles after access;
    // banks not being read drive junk so a wrong slice or capture cycle shows up.
    logic [DW-1:0]     macro_mem [NB*ROWS];
    logic [NB*DW-1:0]  pipe [RD_LAT];
    assign bus.mem_odata = pipe[RD_LAT-1];

    always @(posedge clk) begin
        logic [NB*DW-1:0] v;
        for (int b = 0; b < NB; b++) begin
            v[b*DW +: DW] = DW'($urandom);
            if (bus.mem_ce && !bus.mem_csb[b]) begin
                if (!bus.mem_web)
                    macro_mem[b*ROWS + int'(bus.mem_addr)] <= bus.mem_idata;
                else
                    v[b*DW +: DW] = macro_mem[b*ROWS + int'(bus.mem_addr)];
            end
        end
        pipe[0] <= v;
        for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NB-1:0] sel_of(input logic [AW-1:0] a);
        logic [NB-1:0] s;
        s = '1;
        s[a[AW-1:BANK_AW]] = 1'b0;
        return s;
    endfunction

    // Invariants on the macro strobes, sampled every falling edge out of reset
    always @(negedge clk) begin
        if (rstn) begin
            check("csb_at_most_one_low", 256'($countones(~bus.mem_csb) <= 1), 256'(1));
            check("oeb_at_most_one_low", 256'($countones(~bus.mem_oeb) <= 1), 256'(1));
            if (bus.req_ready || bus.rsp_valid) begin
                check("idle_csb", 256'(bus.mem_csb), 256'({NB{1'b1}}));
                check("idle_oeb", 256'(bus.mem_oeb), 256'({NB{1'b1}}));
                check("idle_ce",  256'(bus.mem_ce), 256'(0));
            end
        end
    end

    int b2b_acc  = 0;
    bit b2b_prev = 1'b0;

    task automatic wait_ready();
        int t = 0;
        while (!bus.req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("req_ready_timeout", 256'(bus.req_ready), 256'(1));
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep);
        int acc;
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(negedge clk);
        acc = cyc;
        if (b2b_prev) check("b2b_accept_spacing", 256'(acc - b2b_acc), 256'(2));
        b2b_acc  = acc;
        b2b_prev = keep;
        check("wr_ce",        256'(bus.mem_ce), 256'(1));
        check("wr_web",       256'(bus.mem_web), 256'(0));
        check("wr_csb",       256'(bus.mem_csb), 256'(sel_of(a)));
        check("wr_oeb",       256'(bus.mem_oeb), 256'({NB{1'b1}}));
        check("wr_addr",      256'(bus.mem_addr), 256'(a[BANK_AW-1:0]));
        check("wr_idata",     256'(bus.mem_idata), 256'(d));
        check("wr_ready_low", 256'(bus.req_ready), 256'(0));
        check("wr_no_rsp",    256'(bus.rsp_valid), 256'(0));
        if (!keep) bus.req_valid = 1'b0;
        if (!ref_mem.exists(int'(a))) written.push_back(a);
        ref_mem[int'(a)] = d;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int hold);
        int acc;
        logic [DW-1:0] exp;
        exp = ref_mem[int'(a)];
        b2b_prev = 1'b0;
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a;
        bus.req_wdata = DW'($urandom);
        @(negedge clk);
        acc = cyc;
        bus.req_valid = 1'b0;
        check("rd_ce",   256'(bus.mem_ce), 256'(1));
        check("rd_web",  256'(bus.mem_web), 256'(1));
        check("rd_csb",  256'(bus.mem_csb), 256'(sel_of(a)));
        check("rd_addr", 256'(bus.mem_addr), 256'(a[BANK_AW-1:0]));
        for (int k = 0; k < RD_LAT; k++) begin
            @(negedge clk);
            check("rd_wait_oeb", 256'(bus.mem_oeb), 256'(sel_of(a)));
            check("rd_wait_csb", 256'(bus.mem_csb), 256'(sel_of(a)));
            check("rd_wait_ce",  256'(bus.mem_ce), 256'(0));
            check("rd_wait_web", 256'(bus.mem_web), 256'(1));
            check("rd_wait_rsp", 256'(bus.rsp_valid), 256'(0));
        end
        @(negedge clk);
        check("rd_rsp_valid", 256'(bus.rsp_valid), 256'(1));
        check("rd_latency",   256'(cyc - acc), 256'(RD_LAT + 1));
        check("rd_data",      256'(bus.rsp_rdata), 256'(exp));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_rsp_valid", 256'(bus.rsp_valid), 256'(1));
            check("hold_rsp_rdata", 256'(bus.rsp_rdata), 256'(exp));
            check("hold_req_ready", 256'(bus.req_ready), 256'(0));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_done_valid", 256'(bus.rsp_valid), 256'(0));
        check("rsp_done_ready", 256'(bus.req_ready), 256'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        // Reset values while held in reset
        repeat (3) @(negedge clk);
        check("rst_req_ready", 256'(bus.req_ready), 256'(1));
        check("rst_rsp_valid", 256'(bus.rsp_valid), 256'(0));
        check("rst_rsp_rdata", 256'(bus.rsp_rdata), 256'(0));
        check("rst_ce",        256'(bus.mem_ce), 256'(0));
        check("rst_web",       256'(bus.mem_web), 256'(1));
        check("rst_csb",       256'(bus.mem_csb), 256'({NB{1'b1}}));
        check("rst_oeb",       256'(bus.mem_oeb), 256'({NB{1'b1}}));
        check("rst_addr",      256'(bus.mem_addr), 256'(0));
        check("rst_idata",     256'(bus.mem_idata), 256'(0));
        rstn = 1'b1;
        @(negedge clk);

        // Single write/read on bank 1, row 3
        do_write(AW'(16'h0403), DW'(8'hA5), 1'b0);
        do_read(AW'(16'h0403), 0);

        // Opposite-end banks at the top row
        do_write(AW'(16'h03FF), DW'(8'h3C), 1'b0);
        do_write({BW'(NB-1), BANK_AW'(ROWS-1)}, DW'(8'hC3), 1'b0);
        do_read(AW'(16'h03FF), 0);
        do_read({BW'(NB-1), BANK_AW'(ROWS-1)}, 0);

        // Back-pressured response
        do_read(AW'(16'h0403), 5);

        // Continuous request stream of writes
        for (int i = 0; i < 6; i++)
            do_write(AW'($urandom), DW'($urandom), i != 5);

        // Randomized mix
        for (int i = 0; i < 300; i++) begin
            if (written.size() == 0 || $urandom_range(0, 2) == 0)
                do_write(AW'($urandom), DW'($urandom), bit'($urandom_range(0, 1)));
            else
                do_read(written[$urandom_range(0, written.size() - 1)], $urandom_range(0, 3));
        end
        do_write(AW'($urandom), DW'($urandom), 1'b0);

        // Reset during the read wait phase aborts the read
        a = written[0];
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_wait_oeb", 256'(bus.mem_oeb), 256'(sel_of(a)));
        #2 rstn = 1'b0;
        #1;
        check("abort_csb",       256'(bus.mem_csb), 256'({NB{1'b1}}));
        check("abort_oeb",       256'(bus.mem_oeb), 256'({NB{1'b1}}));
        check("abort_rsp_valid", 256'(bus.rsp_valid), 256'(0));
        check("abort_ce",        256'(bus.mem_ce), 256'(0));
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < RD_LAT + 4; i++) begin
            @(negedge clk);
            check("abort_no_rsp",  256'(bus.rsp_valid), 256'(0));
            check("abort_ready",   256'(bus.req_ready), 256'(1));
        end

        // Controller still usable after the abort
        do_read(a, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/banked_sram_ctrl.md
BANKED_SRAM_CTRL -- requirements
Module: banked_sram_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_BANKS, default 64, giving the number of external 1RW macro banks (power of two, 2..256).
REQ-002 The block SHALL have parameter BANK_AW, default 10, giving the row address width per bank.
REQ-003 The block SHALL have parameter DW, default 8, giving the data width per bank.
REQ-004 The block SHALL have parameter RD_LAT, default 1, giving the macro read latency in cycles after the access cycle (range 1..4).
REQ-005 The block SHALL derive localparam BW = log2(NUM_BANKS) and AW = BW+BANK_AW.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-007 CLK  in  1  clock; all state updates on the rising edge.
REQ-008 RSTN  in  1  asynchronous active-low reset.
REQ-009 REQ_VALID  in  1  request present.
REQ-010 REQ_READY  out  1  controller accepts a request this cycle.
REQ-011 REQ_WE  in  1  1 = write, 0 = read.
REQ-012 REQ_ADDR  in  AW  address; [AW-1:BANK_AW] = bank, [BANK_AW-1:0] = row.
REQ-013 REQ_WDATA  in  DW  write data.
REQ-014 RSP_VALID  out  1  read data valid.
REQ-015 RSP_READY  in  1  consumer takes the response.
REQ-016 RSP_RDATA  out  DW  read data.
REQ-017 MEM_ADDR  out  BANK_AW  shared macro row address.
REQ-018 MEM_CE  out  1  shared macro enable strobe, active-high.
REQ-019 MEM_WEB  out  1  shared write enable, active-low.
REQ-020 MEM_CSB  out  NUM_BANKS  per-bank chip select, active-low.
REQ-021 MEM_OEB  out  NUM_BANKS  per-bank output enable, active-low.
REQ-022 MEM_IDATA  out  DW  shared write data.
REQ-023 MEM_ODATA  in  NUM_BANKS*DW  flat read bus; bank i at [DW*(i+1)-1:DW*i].

Function
REQ-024 The block SHALL implement FSM states IDLE, ACCESS, WAIT, RESP.
REQ-025 REQ_READY SHALL be 1 only in IDLE; a request is accepted on an edge with REQ_VALID & REQ_READY.
REQ-026 On accept, the block SHALL register bank, row, WE and WDATA and enter ACCESS.
REQ-027 In ACCESS, the block SHALL drive MEM_CE=1, MEM_CSB[bank]=0, all other CSB bits =1, MEM_WEB=~WE, MEM_ADDR=row, MEM_IDATA=WDATA; all MEM_* outputs SHALL be registered.
REQ-028 After ACCESS, a write SHALL return to IDLE with no response, giving a minimum of 2 cycles per write.
REQ-029 After ACCESS, a read SHALL enter WAIT for exactly RD_LAT cycles, with MEM_CSB[bank]=0, MEM_OEB[bank]=0, MEM_CE=0, and MEM_WEB=1.
REQ-030 On the last WAIT edge, the block SHALL capture the MEM_ODATA slice of the registered bank into RSP_RDATA and enter RESP with RSP_VALID=1.
REQ-031 The read latency from the accept edge to RSP_VALID high SHALL be RD_LAT+1 cycles.
REQ-032 In RESP, RSP_VALID and RSP_RDATA SHALL hold stable until RSP_READY=1; on that edge the block SHALL return to IDLE with RSP_VALID=0.
REQ-033 Only one transaction SHALL be outstanding at a time, and REQ_VALID SHALL be ignored outside IDLE.
REQ-034 Outside ACCESS and WAIT, all MEM_CSB and MEM_OEB bits SHALL be 1 and MEM_CE SHALL be 0.
REQ-035 At most one CSB bit and at most one OEB bit SHALL be low in any cycle.
REQ-036 The bank index SHALL be taken directly from the upper address bits, so every address maps to an existing bank.

Reset
REQ-037 When RSTN is low, the block SHALL asynchronously force state IDLE, REQ_READY=1 after release, RSP_VALID=0, RSP_RDATA=0, MEM_CE=0, MEM_WEB=1, MEM_CSB and MEM_OEB all ones, and MEM_ADDR and MEM_IDATA zero.
REQ-038 A reset mid-transaction SHALL abort it: a write in progress has undefined memory contents, and no response is ever issued for an aborted read.

Verification (defaults: 64 banks, BANK_AW=10, DW=8, RD_LAT=1)
REQ-039 Write 0xA5 to addr 0x0403, then read 0x0403 -> MEM_CSB[1]=0 only, MEM_ADDR=0x003, RSP_RDATA=0xA5 two cycles after read accept.
REQ-040 Write to banks 0 and 63 at row 0x3FF with distinct data, then read both -> each read returns its own data, with no cross-bank corruption.
REQ-041 Hold RSP_READY=0 for 5 cycles during a read -> RSP_VALID and RSP_RDATA stable, REQ_READY=0 throughout; one cycle after RSP_READY=1, REQ_READY=1.
REQ-042 Drive REQ_VALID continuously with back-to-back writes -> accepts spaced 2 cycles apart, and no CSB glitch between accesses.
REQ-043 Assert RSTN low during WAIT -> all CSB and OEB bits read 1 immediately, RSP_VALID=0, and RSP_VALID is never raised for that read.
REQ-044 Run with RD_LAT=3 and NUM_BANKS=16 -> read latency of 4 cycles and MEM_OEB low for exactly 3 cycles.
